// File: rtl/vga_ball_renderer.sv
// Pixel stage after the VGA timing generator: draws border, background and a
// bouncing square ball; the ball moves once per frame at the start of vblank.

module vga_ball_axis #(
    parameter int MIN   = 4,
    parameter int MAX   = 620,
    parameter int SPEED = 2,
    parameter int POS0  = 312
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       upd,
    input  logic       pause,
    output logic [9:0] pos
);
    logic [10:0] pos_q, pos_d;
    logic        dir_q, dir_d;   // 1 = increasing
    logic [10:0] step_up, step_dn;

    assign step_up = pos_q + 11'(SPEED);
    assign step_dn = pos_q - 11'(SPEED);

    always_comb begin
        pos_d = pos_q;
        dir_d = dir_q;
        if (upd && !pause) begin
            if (dir_q) begin
                if (step_up >= 11'(MAX)) begin
                    pos_d = 11'(MAX);
                    dir_d = 1'b0;
                end else begin
                    pos_d = step_up;
                end
            end else begin
                if (pos_q <= 11'(MIN + SPEED)) begin
                    pos_d = 11'(MIN);
                    dir_d = 1'b1;
                end else begin
                    pos_d = step_dn;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q <= 11'(POS0);
            dir_q <= 1'b1;
        end else begin
            pos_q <= pos_d;
            dir_q <= dir_d;
        end
    end

    assign pos = pos_q[9:0];
endmodule

module vga_ball_renderer #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int BORDER    = 4,
    parameter int BALL_SIZE = 16,
    parameter int SPEED     = 2,
    parameter int BALL_X0   = 312,
    parameter int BALL_Y0   = 232
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    input  logic        blank_n,
    input  logic        pause,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        frame_tick,
    output logic [15:0] frame_cnt,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y
);
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t C_BLACK  = '{r: 8'h00, g: 8'h00, b: 8'h00};
    localparam rgb_t C_BALL   = '{r: 8'hFF, g: 8'hFF, b: 8'hFF};
    localparam rgb_t C_BORDER = '{r: 8'h00, g: 8'h00, b: 8'hFF};
    localparam rgb_t C_BG     = '{r: 8'h00, g: 8'h40, b: 8'h00};

    rgb_t        rgb_q, rgb_d;
    logic        frame_tick_q, frame_tick_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        tick_cond;
    logic [10:0] h_ext, v_ext, bx_ext, by_ext;
    logic        in_ball, in_border;

    assign tick_cond = (h_count == 10'd0) && (v_count == 10'(V_ACTIVE));

    vga_ball_axis #(
        .MIN(BORDER), .MAX(H_ACTIVE - BORDER - BALL_SIZE), .SPEED(SPEED), .POS0(BALL_X0)
    ) u_axis_x (
        .clk(clk), .rst(rst), .upd(tick_cond), .pause(pause), .pos(ball_x)
    );

    vga_ball_axis #(
        .MIN(BORDER), .MAX(V_ACTIVE - BORDER - BALL_SIZE), .SPEED(SPEED), .POS0(BALL_Y0)
    ) u_axis_y (
        .clk(clk), .rst(rst), .upd(tick_cond), .pause(pause), .pos(ball_y)
    );

    // Draw with the pre-update position; it only moves inside vblank anyway.
    assign h_ext  = {1'b0, h_count};
    assign v_ext  = {1'b0, v_count};
    assign bx_ext = {1'b0, ball_x};
    assign by_ext = {1'b0, ball_y};

    assign in_ball = (h_ext >= bx_ext) && (h_ext < bx_ext + 11'(BALL_SIZE)) &&
                     (v_ext >= by_ext) && (v_ext < by_ext + 11'(BALL_SIZE));
    assign in_border = (h_ext < 11'(BORDER)) || (h_ext >= 11'(H_ACTIVE - BORDER)) ||
                       (v_ext < 11'(BORDER)) || (v_ext >= 11'(V_ACTIVE - BORDER));

    always_comb begin
        rgb_d        = C_BG;
        frame_tick_d = tick_cond;
        frame_cnt_d  = frame_cnt_q;
        if (tick_cond) frame_cnt_d = frame_cnt_q + 16'd1;
        if (!blank_n)       rgb_d = C_BLACK;
        else if (in_ball)   rgb_d = C_BALL;
        else if (in_border) rgb_d = C_BORDER;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q        <= C_BLACK;
            frame_tick_q <= 1'b0;
            frame_cnt_q  <= 16'd0;
        end else begin
            rgb_q        <= rgb_d;
            frame_tick_q <= frame_tick_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign VGA_R      = rgb_q.r;
    assign VGA_G      = rgb_q.g;
    assign VGA_B      = rgb_q.b;
    assign frame_tick = frame_tick_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_vga_ball_renderer.sv
// Bench for vga_ball_renderer: directed vectors and bounce sequences, then
// randomized pixels/ticks checked against a frame-level reference model.

module tb_vga_ball_renderer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  h_count = '0, v_count = '0;
    logic        blank_n = 1'b0, pause = 1'b0;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        frame_tick;
    logic [15:0] frame_cnt;
    logic [9:0]  ball_x, ball_y;

    int checks = 0;
    int errors = 0;

    vga_ball_renderer dut (
        .clk(clk), .rst(rst), .h_count(h_count), .v_count(v_count),
        .blank_n(blank_n), .pause(pause), .VGA_R(VGA_R), .VGA_G(VGA_G),
        .VGA_B(VGA_B), .frame_tick(frame_tick), .frame_cnt(frame_cnt),
        .ball_x(ball_x), .ball_y(ball_y)
    );

    always #5 clk = ~clk;

    // Reference model state: ball position/direction and frame counter.
    int mx, my, mcnt;
    bit mdx, mdy;
    logic [23:0] m_rgb;
    bit m_tick;
    bit chk_all = 0;

    function automatic logic [23:0] pix(int h, int v, bit b, int bx, int by);
        if (!b) return 24'h000000;
        if (h >= bx && h < bx + 16 && v >= by && v < by + 16) return 24'hFFFFFF;
        if (h < 4 || h >= 636 || v < 4 || v >= 476) return 24'h0000FF;
        return 24'h004000;
    endfunction

    task automatic move(inout int p, inout bit d, input int lo, input int hi);
        if (d) begin
            if (p + 2 >= hi) begin p = hi; d = 0; end else p = p + 2;
        end else begin
            if (p <= lo + 2) begin p = lo; d = 1; end else p = p - 2;
        end
    endtask

    task automatic model_reset();
        mx = 312; my = 232; mdx = 1; mdy = 1; mcnt = 0; m_rgb = 0; m_tick = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int h, input int v, input bit b, input bit p);
        bit tc;
        h_count = 10'(h); v_count = 10'(v); blank_n = b; pause = p;
        tc = (h == 0 && v == 480);
        @(posedge clk);
        m_rgb  = pix(h, v, b, mx, my);
        m_tick = tc;
        if (tc) begin
            mcnt = (mcnt + 1) % 65536;
            if (!p) begin
                move(mx, mdx, 4, 620);
                move(my, mdy, 4, 460);
            end
        end
        #1;
        if (chk_all) begin
            chk("rand_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, m_rgb});
            chk("rand_tick", {31'h0, frame_tick}, {31'h0, m_tick});
            chk("rand_cnt", {16'h0, frame_cnt}, 32'(mcnt));
            chk("rand_x", {22'h0, ball_x}, 32'(mx));
            chk("rand_y", {22'h0, ball_y}, 32'(my));
        end
    endtask

    task automatic tick_once(input bit p);
        step(0, 480, 0, p);
        step(5, 480, 0, p);
    endtask

    typedef struct {
        int h;
        int v;
        bit b;
        logic [23:0] exp;
    } vec_t;

    vec_t vecs[6];
    int   sx, sy, scnt;

    initial begin
        vecs[0] = '{h: 0,   v: 0,   b: 1, exp: 24'h0000FF};
        vecs[1] = '{h: 100, v: 100, b: 1, exp: 24'h004000};
        vecs[2] = '{h: 312, v: 232, b: 1, exp: 24'hFFFFFF};
        vecs[3] = '{h: 327, v: 247, b: 1, exp: 24'hFFFFFF};
        vecs[4] = '{h: 328, v: 232, b: 1, exp: 24'h004000};
        vecs[5] = '{h: 700, v: 100, b: 0, exp: 24'h000000};

        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Move things away from reset values, then reset mid-line.
        repeat (3) tick_once(0);
        step(320, 240, 1, 0);
        chk("pre_rst_moved", {22'h0, ball_x}, 32'd318);
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("rst_rgb", {8'h0, VGA_R, VGA_G, VGA_B}, 32'h0);
        chk("rst_x", {22'h0, ball_x}, 32'd312);
        chk("rst_y", {22'h0, ball_y}, 32'd232);
        chk("rst_tick", {31'h0, frame_tick}, 32'h0);
        chk("rst_cnt", {16'h0, frame_cnt}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        model_reset();

        foreach (vecs[i]) begin
            step(vecs[i].h, vecs[i].v, vecs[i].b, 0);
            chk($sformatf("pix%0d", i), {8'h0, VGA_R, VGA_G, VGA_B}, {8'h0, vecs[i].exp});
        end

        // First tick after release, then bounce sequences.
        step(0, 480, 0, 0);
        chk("first_tick", {31'h0, frame_tick}, 32'h1);
        chk("first_cnt", {16'h0, frame_cnt}, 32'd1);
        step(1, 480, 0, 0);
        chk("tick_oneshot", {31'h0, frame_tick}, 32'h0);
        chk("cnt_hold", {16'h0, frame_cnt}, 32'd1);

        for (int n = 2; n <= 463; n++) begin
            tick_once(0);
            if (n == 114) chk("bottom_hit", {22'h0, ball_y}, 32'd460);
            if (n == 115) chk("bottom_back", {22'h0, ball_y}, 32'd458);
            if (n == 154) chk("right_hit", {22'h0, ball_x}, 32'd620);
            if (n == 155) chk("right_back", {22'h0, ball_x}, 32'd618);
            if (n == 342) chk("top_clamp", {22'h0, ball_y}, 32'd4);
            if (n == 461) chk("left_pre", {22'h0, ball_x}, 32'd6);
            if (n == 462) chk("left_clamp", {22'h0, ball_x}, 32'd4);
            if (n == 463) chk("left_turn", {22'h0, ball_x}, 32'd6);
        end

        sx = ball_x; sy = ball_y; scnt = frame_cnt;
        chk("pre_pause_cnt", 32'(scnt), 32'd463);
        repeat (10) tick_once(1);
        chk("pause_x", {22'h0, ball_x}, 32'(sx));
        chk("pause_y", {22'h0, ball_y}, 32'(sy));
        chk("pause_cnt", {16'h0, frame_cnt}, 32'(scnt + 10));
        tick_once(0);
        chk("resume_x", {22'h0, ball_x}, 32'(sx + 2));
        chk("resume_y", {22'h0, ball_y}, 32'(my));

        // Random phase: every cycle checked against the model.
        chk_all = 1;
        for (int i = 0; i < 4000; i++) begin
            int h, v;
            bit b, p;
            if ($urandom_range(15) == 0) begin
                h = 0; v = 480;
            end else if ($urandom_range(1) == 0) begin
                h = mx + int'($urandom_range(20)) - 2;
                v = my + int'($urandom_range(20)) - 2;
            end else begin
                h = $urandom_range(799);
                v = $urandom_range(524);
            end
            b = ($urandom_range(7) != 0);
            p = ($urandom_range(3) == 0);
            step(h, v, b, p);
        end
        chk_all = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/vga_ball_renderer.md
Name: vga_ball_renderer

Overview:
- Pixel-generation stage directly downstream of the VGA timing generator, in the 25 MHz pixel-clock domain.
- Consumes the timing generator's h_count, v_count and VGA_BLANK_N.
- Produces registered 8-bit R/G/B for the DAC: a fixed border, a background, and a square ball that bounces off the border.
- Ball position updates once per frame, at the start of vertical blanking, so the picture never tears.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BORDER, 4, border thickness in pixels on all four edges
BALL_SIZE, 16, ball edge length in pixels
SPEED, 2, pixels moved per frame on each axis
BALL_X0, 312, ball left edge after reset
BALL_Y0, 232, ball top edge after reset

Ports:
clk  in  1  pixel clock (25 MHz divided clock from the timing stage)
rst  in  1  asynchronous active-high reset
h_count  in  10  current horizontal position from the timing stage
v_count  in  10  current vertical position from the timing stage
blank_n  in  1  high in the active video region
pause  in  1  level; when high, the ball holds position and direction
VGA_R  out  8  red
VGA_G  out  8  green
VGA_B  out  8  blue
frame_tick  out  1  one-cycle pulse on each ball update point
frame_cnt  out  16  frames since reset, wraps 65535->0
ball_x  out  10  current ball left edge
ball_y  out  10  current ball top edge

Behaviour:
Reset:
- One clock; reset is asynchronous and active-high. Assertion takes effect immediately, including mid-line or mid-frame.
- Reset values: VGA_R/G/B=0, frame_tick=0, frame_cnt=0, ball_x=BALL_X0, ball_y=BALL_Y0, dx=+1, dy=+1.
- After release, output resumes on the next clock from whatever counts arrive. No resynchronisation to frame start is required.

Update point:
- tick_cond = (h_count==0 && v_count==V_ACTIVE).
- On the clock edge where tick_cond is true: frame_tick<=1, frame_cnt<=frame_cnt+1, and the ball update below is applied. frame_tick is 0 on all other edges.
- frame_tick and frame_cnt pulse and increment even when pause=1.

Ball update (per axis, shown for x; y is identical with YMIN/YMAX):
- XMIN=BORDER. XMAX=H_ACTIVE-BORDER-BALL_SIZE (620 with defaults). YMIN=BORDER. YMAX=V_ACTIVE-BORDER-BALL_SIZE (460 with defaults).
- pause=1: no change to position or direction.
- dx=+ and ball_x+SPEED>=XMAX: ball_x<=XMAX, dx<=-.
- dx=- and ball_x<=XMIN+SPEED: ball_x<=XMIN, dx<=+.
- Otherwise: ball_x<=ball_x±SPEED.
- Axes update independently. A corner hit flips both directions on the same tick.
- Arithmetic is 11-bit internally; no wrap-around is possible.

Pixel path (1-cycle latency, matching the timing stage's registered syncs):
- RGB is registered from the h_count/v_count/blank_n sampled on the same edge.
- blank_n=0: RGB=00/00/00.
- Otherwise priority ball > border > background:
  - ball when h in [ball_x, ball_x+BALL_SIZE) and v in [ball_y, ball_y+BALL_SIZE): FF/FF/FF.
  - border when h<BORDER, h>=H_ACTIVE-BORDER, v<BORDER or v>=V_ACTIVE-BORDER: 00/00/FF.
  - background: 00/40/00.
- Ball position used for drawing is the registered ball_x/ball_y. It only changes during vertical blank, so a whole visible frame uses one position.

Test Plan:
- Reset and first frame: assert rst mid-line, then release -> RGB=0, ball_x=312, ball_y=232 during reset; first tick_cond after release gives frame_tick=1 for one cycle, frame_cnt=1.
- Pixel colours, each checked one clock after the inputs are applied:
  - (h=0,v=0,blank_n=1) -> 00/00/FF.
  - (h=100,v=100) -> 00/40/00.
  - (h=312,v=232) -> FF/FF/FF.
  - (h=327,v=247) -> FF/FF/FF.
  - (h=328,v=232) -> 00/40/00.
  - (h=700,v=100,blank_n=0) -> 00/00/00.
- Right bounce: 154 ticks after reset -> ball_x=620, dx=-; tick 155 -> ball_x=618.
- Bottom bounce: 114 ticks -> ball_y=460; tick 115 -> ball_y=458.
- Left/top clamp: drive the ball toward XMIN; from ball_x=6 with dx=- one tick -> ball_x=4, dx=+.
- Pause: hold pause=1 across 10 ticks -> ball_x/ball_y unchanged, frame_cnt advances by 10; release -> motion resumes in the stored direction.
